// File: rtl/jk_pkg.sv
// Shared types and constants for the JK bank arbiter.
//   state_t : arbiter FSM states (IDLE / APPLY / ACK)
//   HOLD/CLR/SET/TGL : per-bit {j,k} command encodings
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One bank bit: JK flip-flop with enable.
//   clk, reset : clock, async active-high reset (q -> 0)
//   en         : apply {j,k} command this edge, otherwise hold
//   j, k       : JK command
//   q          : registered bit state
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK update, gated by en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        HOLD:    q <= q;
        CLR:     q <= 1'b0;
        SET:     q <= 1'b1;
        TGL:     q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a shared JK bank.
//   clk, reset : clock, async active-high reset
//   req        : per-requester level request
//   j_in, k_in : per-requester JK masks, requester i at [i*WIDTH +: WIDTH]
//   clr        : bank clear, honoured only in IDLE, beats req
//   q          : bank state
//   ack        : one-cycle one-hot completion pulse
//   gnt_id     : current / most recent winner
//   busy       : transaction in flight (APPLY or ACK)
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    j_in,
  input  logic [NREQ*WIDTH-1:0]    k_in,
  input  logic                     clr,
  output logic [WIDTH-1:0]         q,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_t           state, state_next;
  logic [IDW-1:0]   rr_ptr, rr_next;
  logic [IDW-1:0]   gnt_next;
  logic [IDW-1:0]   win;
  logic             found;
  int unsigned      cand;
  logic [NREQ-1:0]  ack_next;
  logic             busy_next;
  logic             lat_en;
  logic [WIDTH-1:0] j_lat, k_lat;
  logic [WIDTH-1:0] j_sel, k_sel;
  logic             cell_en;
  logic [WIDTH-1:0] cell_j, cell_k;

  // Round-robin search: first set req bit at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr) + i) % NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IDW'(cand);
      end
    end
  end

  assign j_sel = j_in[32'(win)*WIDTH +: WIDTH];
  assign k_sel = k_in[32'(win)*WIDTH +: WIDTH];

  // Next-state and registered-output logic
  always_comb begin
    state_next = state;
    gnt_next   = gnt_id;
    rr_next    = rr_ptr;
    ack_next   = '0;
    busy_next  = 1'b0;
    lat_en     = 1'b0;
    cell_en    = 1'b0;
    cell_j     = '0;
    cell_k     = '0;
    case (state)
      IDLE: begin
        if (clr) begin
          // bank clear is a CLR command on every bit
          cell_en = 1'b1;
          cell_k  = '1;
        end else if (found) begin
          state_next = APPLY;
          gnt_next   = win;
          lat_en     = 1'b1;
          busy_next  = 1'b1;
        end
      end
      APPLY: begin
        cell_en    = 1'b1;
        cell_j     = j_lat;
        cell_k     = k_lat;
        state_next = ACK;
        busy_next  = 1'b1;
      end
      ACK: begin
        state_next       = IDLE;
        ack_next[gnt_id] = 1'b1;
        rr_next          = (gnt_id == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_id + 1'b1);
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer, latched masks and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      ack    <= '0;
      busy   <= 1'b0;
      j_lat  <= '0;
      k_lat  <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      gnt_id <= gnt_next;
      ack    <= ack_next;
      busy   <= busy_next;
      if (lat_en) begin
        j_lat <= j_sel;
        k_lat <= k_sel;
      end
    end
  end

  // Bank storage
  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (cell_en),
      .j     (cell_j[b]),
      .k     (cell_k[b]),
      .q     (q[b])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (NREQ=4, WIDTH=8).
module tb_jk_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ*WIDTH-1:0]   j_in = '0;
  logic [NREQ*WIDTH-1:0]   k_in = '0;
  logic                    clr = 1'b0;
  logic [WIDTH-1:0]        q;
  logic [NREQ-1:0]         ack;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                    busy;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .j_in   (j_in),
    .k_in   (k_in),
    .clr    (clr),
    .q      (q),
    .ack    (ack),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input int i, input logic [7:0] j, input logic [7:0] k);
    j_in[i*WIDTH +: WIDTH] = j;
    k_in[i*WIDTH +: WIDTH] = k;
  endtask

  // One full transaction with req held until the ack edge
  task automatic run_txn(input string tag, input int exp_id, input logic [7:0] exp_q);
    tick();
    check_eq({tag, ".gnt"},   32'(gnt_id), 32'(exp_id));
    check_eq({tag, ".busy1"}, 32'(busy), 32'd1);
    check_eq({tag, ".ack1"},  32'(ack), 32'd0);
    tick();
    check_eq({tag, ".q"},     32'(q), 32'(exp_q));
    check_eq({tag, ".busy2"}, 32'(busy), 32'd1);
    check_eq({tag, ".ack2"},  32'(ack), 32'd0);
    tick();
    check_eq({tag, ".ack"},   32'(ack), 32'(1 << exp_id));
    check_eq({tag, ".busy3"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst.q",    32'(q), 32'd0);
    check_eq("rst.ack",  32'(ack), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.gnt",  32'(gnt_id), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle.busy", 32'(busy), 32'd0);

    // Single set: q=F0 one edge after latch
    set_mask(0, 8'hF0, 8'h00);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    check_eq("set.busy1", 32'(busy), 32'd1);
    check_eq("set.q0",    32'(q), 32'h00);
    tick();
    check_eq("set.q",     32'(q), 32'hF0);
    check_eq("set.ack_early", 32'(ack), 32'd0);
    tick();
    check_eq("set.ack",   32'(ack), 32'b0001);
    check_eq("set.busy3", 32'(busy), 32'd0);
    tick();
    check_eq("set.ack_off", 32'(ack), 32'd0);

    // Toggle/set/clear/hold mix on 0xF0 with J=CC K=AA gives 0x5C
    set_mask(1, 8'hCC, 8'hAA);
    req = 4'b0010;
    run_txn("mix", 1, 8'h5C);
    req = 4'b0000;

    // Reset during APPLY aborts with q forced to 0
    set_mask(2, 8'hFF, 8'h00);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check_eq("rsta.busy_pre", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("rsta.q",    32'(q), 32'd0);
    check_eq("rsta.ack",  32'(ack), 32'd0);
    check_eq("rsta.busy", 32'(busy), 32'd0);
    check_eq("rsta.gnt",  32'(gnt_id), 32'd0);
    tick();
    reset = 1'b0;

    // Round robin with req=1111 held; requester 0 toggles bit 0
    set_mask(0, 8'h01, 8'h01);
    set_mask(1, 8'h02, 8'h00);
    set_mask(2, 8'h04, 8'h00);
    set_mask(3, 8'h08, 8'h00);
    req = 4'b1111;
    run_txn("rr0", 0, 8'h01);
    run_txn("rr1", 1, 8'h03);
    run_txn("rr2", 2, 8'h07);
    run_txn("rr3", 3, 8'h0F);
    run_txn("rr4", 0, 8'h0E);
    req = 4'b0000;

    // Load 0xFF, then clr beats a same-cycle req
    set_mask(0, 8'hFF, 8'h00);
    req = 4'b0001;
    run_txn("ff", 0, 8'hFF);
    req = 4'b0000;
    set_mask(1, 8'h0F, 8'h00);
    clr = 1'b1;
    req = 4'b0010;
    tick();
    clr = 1'b0;
    check_eq("clr.q",    32'(q), 32'h00);
    check_eq("clr.ack",  32'(ack), 32'd0);
    check_eq("clr.busy", 32'(busy), 32'd0);
    run_txn("clr_next", 1, 8'h0F);
    req = 4'b0000;

    // Only the winner's masks reach the bank
    set_mask(0, 8'hFF, 8'hFF);
    set_mask(1, 8'hFF, 8'h00);
    set_mask(3, 8'h00, 8'hFF);
    set_mask(2, 8'h30, 8'h01);
    req = 4'b0100;
    run_txn("iso", 2, 8'h3E);
    req = 4'b0000;

    // clr during APPLY and ACK is ignored
    set_mask(0, 8'h80, 8'h00);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    clr = 1'b1;
    tick();
    check_eq("clrig.q1", 32'(q), 32'hBE);
    tick();
    clr = 1'b0;
    check_eq("clrig.q2",  32'(q), 32'hBE);
    check_eq("clrig.ack", 32'(ack), 32'b0001);
    tick();
    check_eq("idle.q", 32'(q), 32'hBE);
    check_eq("idle.busy2", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
